regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
Write-side controller for the 32x32 register file. It collects results from the ALU (single-cycle) and the LSU (multi-cycle loads), arbitrates between them, and drives the register file write port (we/waddr/wdata). It also keeps a pending-write scoreboard that decode uses to detect RAW hazards. It sits between the execute/memory stages and the register file.

Parameters:
XLEN, 32, data width of results and of wdata
AW, 5, register address width (2**AW registers)
ALU_DEPTH, 2, ALU result FIFO depth in entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
alu_valid  in  1  ALU result valid
alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready
alu_rd  in  AW  ALU destination register
alu_data  in  XLEN  ALU result
lsu_valid  in  1  load result valid, one-cycle pulse, always accepted
lsu_rd  in  AW  load destination register
lsu_data  in  XLEN  load data
issue_valid  in  1  decode issuing an instruction with a destination
issue_rd  in  AW  destination of the issued instruction
we  out  1  register file write enable (registered)
waddr  out  AW  register file write address (registered)
wdata  out  XLEN  register file write data (registered)
pending  out  2**AW  bit i=1: a write to register i is outstanding
fifo_count  out  clog2(ALU_DEPTH)+1  ALU FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): we=0, waddr=0, wdata=0, FIFO empty, fifo_count=0, pending=0. Any in-flight FIFO entries are discarded and no write is issued. alu_ready=1 once the FIFO is empty.
- alu_ready = (fifo_count != ALU_DEPTH). It is combinational from registered count only. There is no same-cycle pop-through when full.
- ALU push: on an edge where alu_valid && alu_ready && alu_rd!=0, {alu_rd, alu_data} enters the FIFO tail.
  - alu_rd==0 is accepted (handshake completes) but dropped: no push, no write.
- Arbitration, evaluated each cycle, LSU has strict priority:
  - If lsu_valid && lsu_rd!=0: next we=1, waddr=lsu_rd, wdata=lsu_data. FIFO does not pop.
  - Else if the FIFO is non-empty: pop the head; next we=1, waddr=head.rd, wdata=head.data.
  - Else: next we=0. waddr/wdata hold their previous values.
  - lsu_valid with lsu_rd==0 is ignored, and the FIFO may pop in that cycle.
- Latency:
  - LSU result presented in cycle N: we=1 in cycle N+1.
  - ALU result accepted at edge ending cycle N, FIFO empty, no LSU traffic: head pops in cycle N+1, we=1 in cycle N+2.
- FIFO ordering is strict: ALU results are written in acceptance order.
- Simultaneous push and pop in the same cycle is legal. fifo_count is unchanged. With count=1, the popped entry is the old head, not the new push.
- Pointer wrap-around: read/write pointers are modulo ALU_DEPTH. Occupancy comes from the count, never from pointer equality alone.
- Scoreboard:
  - Set: issue_valid && issue_rd!=0 sets pending[issue_rd] at the edge.
  - Clear: the edge that loads we=1, waddr=r clears pending[r].
  - Same-edge set and clear of the same index: set wins (a newer producer is outstanding).
  - pending[0] is constant 0.
  - Issuing twice to the same rd before its first write: the first write clears the bit. Decode does not issue a second writer to a pending rd; the design does not count multiple writers.
- we is a pure one-cycle-per-write pulse. Consecutive writes produce consecutive we=1 cycles with no bubble.

Test Plan:
1. Reset, then a single ALU result: alu_rd=2, alu_data=255 pulsed in cycle 0 → alu_ready=1; we=1, waddr=2, wdata=255 in cycle 2; we=0 in cycle 3; fifo_count returns to 0.
2. LSU priority: ALU rd=4/511 accepted in cycle 0, LSU rd=5/0xDEAD pulsed in cycle 1 → cycle 2 writes 5/0xDEAD, cycle 3 writes 4/511.
3. FIFO full: ALU_DEPTH=2, lsu_valid held as pulses every cycle, 3 ALU results offered back-to-back → alu_ready drops after 2 accepts, third held. Once LSU stops, writes occur in order (rd 1,2,3), and the third is accepted only after a pop.
4. x0 suppression: ALU rd=0/0x1234 and LSU rd=0/0x5678 → both handshakes complete, we stays 0, fifo_count stays 0.
5. Scoreboard: issue_rd=7 in cycle 0 → pending[7]=1 from cycle 1. ALU rd=7 write → pending[7]=0 the cycle we=1. Issue rd=7 on the same edge as the write of rd=7 → pending[7] stays 1.
6. Mid-operation reset: two ALU entries queued, rst=0 asserted asynchronously mid-cycle → we=0 immediately, fifo_count=0, pending=0; no write after rst returns to 1.

Source files
------------

// File: rtl/regfile_writeback.sv
// Register file write-back controller.
// Buffers ALU results in a small FIFO, gives loads strict priority over the
// FIFO head, drives a registered write port and tracks outstanding writes
// per register so decode can detect RAW hazards.
module regfile_writeback #(
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int ALU_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [AW-1:0]                alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         lsu_valid,
  input  logic [AW-1:0]                lsu_rd,
  input  logic [XLEN-1:0]              lsu_data,
  input  logic                         issue_valid,
  input  logic [AW-1:0]                issue_rd,
  output logic                         we,
  output logic [AW-1:0]                waddr,
  output logic [XLEN-1:0]              wdata,
  output logic [(2**AW)-1:0]           pending,
  output logic [$clog2(ALU_DEPTH):0]   fifo_count
);

  localparam int PW   = $clog2(ALU_DEPTH);
  localparam int CW   = $clog2(ALU_DEPTH) + 1;
  localparam int NREG = 2**AW;

  logic [AW-1:0]   fifo_rd   [ALU_DEPTH];
  logic [XLEN-1:0] fifo_data [ALU_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            push;
  logic            pop;
  logic            lsu_take;
  logic            write_next;
  logic [AW-1:0]   waddr_next;
  logic [XLEN-1:0] wdata_next;
  logic [NREG-1:0] pending_next;

  // Full is judged from the registered count only, so a pop in the same
  // cycle never frees a slot for a push.
  assign alu_ready  = (count != CW'(ALU_DEPTH));
  assign fifo_count = count;

  // Results for x0 complete their handshake but are never buffered or written.
  assign push     = alu_valid && alu_ready && (alu_rd != '0);
  assign lsu_take = lsu_valid && (lsu_rd != '0);
  assign pop      = !lsu_take && (count != '0);

  // Select the next write: loads first, then the FIFO head, else hold the bus.
  always_comb begin
    write_next = 1'b0;
    waddr_next = waddr;
    wdata_next = wdata;
    if (lsu_take) begin
      write_next = 1'b1;
      waddr_next = lsu_rd;
      wdata_next = lsu_data;
    end else if (pop) begin
      write_next = 1'b1;
      waddr_next = fifo_rd[rd_ptr];
      wdata_next = fifo_data[rd_ptr];
    end
  end

  // Clear the bit being written, then set the newly issued one so a newer
  // producer on the same register stays visible.
  always_comb begin
    pending_next = pending;
    if (write_next) begin
      pending_next[waddr_next] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // FIFO storage needs no reset; occupancy is tracked by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= alu_rd;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port and hazard scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      pending <= '0;
    end else begin
      we      <= write_next;
      waddr   <= waddr_next;
      wdata   <= wdata_next;
      pending <= pending_next;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Testbench for regfile_writeback: directed scenarios plus random traffic,
// checked against a queue-based reference model and a write scoreboard.
module tb_regfile_writeback;

  localparam int XLEN      = 32;
  localparam int AW        = 5;
  localparam int ALU_DEPTH = 2;

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  logic                       clk;
  logic                       rst;
  logic                       alu_valid;
  logic                       alu_ready;
  logic [AW-1:0]              alu_rd;
  logic [XLEN-1:0]            alu_data;
  logic                       lsu_valid;
  logic [AW-1:0]              lsu_rd;
  logic [XLEN-1:0]            lsu_data;
  logic                       issue_valid;
  logic [AW-1:0]              issue_rd;
  logic                       we;
  logic [AW-1:0]              waddr;
  logic [XLEN-1:0]            wdata;
  logic [(2**AW)-1:0]         pending;
  logic [$clog2(ALU_DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  wr_t              model_fifo[$];
  wr_t              exp_q[$];
  logic [31:0]      m_pending;
  logic             m_we;
  logic [AW-1:0]    m_waddr;
  logic [XLEN-1:0]  m_wdata;

  regfile_writeback #(.XLEN(XLEN), .AW(AW), .ALU_DEPTH(ALU_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .we(we), .waddr(waddr), .wdata(wdata), .pending(pending), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write scoreboard monitor: every presented write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b1 && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got waddr=%0d wdata=0x%0h with nothing expected", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        checkOutput("sb_waddr", 32'(waddr), 32'(e.rd));
        checkOutput("sb_wdata", wdata, e.data);
      end
    end
  end

  // Advance to the sampling point and compare cycle-level outputs with the model.
  task automatic step();
    @(negedge clk);
    checkOutput("we", 32'(we), 32'(m_we));
    checkOutput("waddr", 32'(waddr), 32'(m_waddr));
    checkOutput("wdata", wdata, m_wdata);
    checkOutput("fifo_count", 32'(fifo_count), 32'(model_fifo.size()));
    checkOutput("alu_ready", 32'(alu_ready), 32'(model_fifo.size() != ALU_DEPTH));
    checkOutput("pending", pending, m_pending);
  endtask

  // Drive one cycle of inputs and advance the model across the coming edge.
  task automatic applyStimulus(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] adata,
                               input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ldata,
                               input logic iv, input logic [AW-1:0] ird, output logic accepted);
    wr_t w;
    logic wr;
    alu_valid = av;  alu_rd = ard;  alu_data = adata;
    lsu_valid = lv;  lsu_rd = lrd;  lsu_data = ldata;
    issue_valid = iv; issue_rd = ird;
    accepted = av && (model_fifo.size() != ALU_DEPTH);
    wr = 1'b0;
    if (lv && lrd != 0) begin
      wr = 1'b1; w.rd = lrd; w.data = ldata;
    end else if (model_fifo.size() > 0) begin
      wr = 1'b1; w = model_fifo.pop_front();
    end
    if (accepted && ard != 0) begin
      wr_t n;
      n.rd = ard; n.data = adata;
      model_fifo.push_back(n);
    end
    m_we = wr;
    if (wr) begin
      m_waddr = w.rd;
      m_wdata = w.data;
      m_pending[w.rd] = 1'b0;
      exp_q.push_back(w);
    end
    if (iv && ird != 0) m_pending[ird] = 1'b1;
  endtask

  task automatic idle();
    logic acc;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic modelReset();
    model_fifo.delete();
    exp_q.delete();
    m_pending = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  initial begin
    logic acc;
    int idx;
    rst = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single ALU result: write appears two cycles after acceptance.
    step();
    checkOutput("t1_ready", 32'(alu_ready), 32'd1);
    applyStimulus(1, 2, 255, 0, 0, 0, 0, 0, acc);
    step(); idle();
    step();
    checkOutput("t1_we", 32'(we), 32'd1);
    checkOutput("t1_waddr", 32'(waddr), 32'd2);
    checkOutput("t1_wdata", wdata, 32'd255);
    idle();
    step();
    checkOutput("t1_we_off", 32'(we), 32'd0);
    checkOutput("t1_count", 32'(fifo_count), 32'd0);
    idle();

    // LSU overtakes a buffered ALU result.
    step(); applyStimulus(1, 4, 511, 0, 0, 0, 0, 0, acc);
    step(); applyStimulus(0, 0, 0, 1, 5, 32'hDEAD, 0, 0, acc);
    step();
    checkOutput("t2_lsu_addr", 32'(waddr), 32'd5);
    checkOutput("t2_lsu_data", wdata, 32'hDEAD);
    idle();
    step();
    checkOutput("t2_alu_addr", 32'(waddr), 32'd4);
    idle();

    // FIFO fills while loads hog the port; third result waits for a pop.
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 3) checkOutput("t3_full_ready", 32'(alu_ready), 32'd0);
      applyStimulus(idx < 3, AW'(idx + 1), 32'(100 + idx), c < 6, 5'd20, 32'(c), 0, 0, acc);
      if (acc && idx < 3) idx++;
    end
    checkOutput("t3_all_accepted", 32'(idx), 32'd3);

    // x0 results are accepted but never written.
    step(); applyStimulus(1, 0, 32'h1234, 1, 0, 32'h5678, 0, 0, acc);
    checkOutput("t4_x0_accept", 32'(acc), 32'd1);
    step();
    checkOutput("t4_we", 32'(we), 32'd0);
    checkOutput("t4_count", 32'(fifo_count), 32'd0);
    idle();

    // Scoreboard set, clear, and set-wins-over-clear.
    step(); applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, acc);
    step();
    checkOutput("t5_set", 32'(pending[7]), 32'd1);
    applyStimulus(1, 7, 32'h77, 0, 0, 0, 0, 0, acc);
    step(); idle();
    step();
    checkOutput("t5_clear", 32'(pending[7]), 32'd0);
    applyStimulus(0, 0, 0, 1, 7, 32'h99, 1, 7, acc);
    step();
    checkOutput("t5_set_wins", 32'(pending[7]), 32'd1);
    idle();
    repeat (3) begin step(); idle(); end

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      step();
      applyStimulus(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 9)), $urandom(),
                    ($urandom_range(0, 3) == 0), AW'($urandom_range(0, 9)), $urandom(),
                    ($urandom_range(0, 1) == 1), AW'($urandom_range(0, 12)), acc);
    end
    repeat (6) begin step(); idle(); end
    checkOutput("exp_drained", 32'(exp_q.size()), 32'd0);

    // Mid-cycle asynchronous reset discards queued entries.
    step(); applyStimulus(1, 3, 32'h33, 1, 9, 32'h90, 1, 3, acc);
    step(); applyStimulus(1, 4, 32'h44, 1, 10, 32'h91, 1, 4, acc);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_we", 32'(we), 32'd0);
    checkOutput("t6_count", 32'(fifo_count), 32'd0);
    checkOutput("t6_pending", pending, 32'd0);
    modelReset();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin step(); idle(); end
    checkOutput("t6_no_write", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
